tvp7002_mode_lock_ctrl: RTL and testbench
=========================================

// Module: tvp7002_mode_lock_ctrl
// PURPOSE
//  Sequences the TVP7002 frontend through sync acquisition, mode verification and lock.
//  Watches per-frame measurements (vtotal, pcnt_frame, interlace, hsync_width); declares a mode valid after N consistent frames.
//  Raises a sticky IRQ to the CPU on lock/unlock and blanks frontend output until locked. Sits in the CLK_MEAS_i domain, beside the frontend.
// PARAMETERS
//  STABLE_FRAMES   3          consecutive consistent measurements (incl. first capture) needed to lock; range 2..15
//  VTOTAL_TOL      1          max |vtotal delta| in lines still counted as a match
//  PCNT_TOL_SHIFT  8          pcnt_frame tolerance = cand_pcnt >> PCNT_TOL_SHIFT (~0.4%)
//  TIMEOUT_CYC     2700000    cycles with no frame_tick before sync is declared lost (100 ms @ 27 MHz)
// PORTS
//  CLK_MEAS_i        in   1   measurement clock; the only clock
//  reset             in   1   synchronous, active-high reset
//  enable_i          in   1   controller enable; low forces IDLE
//  sync_active_i     in   1   sync activity flag from frontend
//  frame_tick_i      in   1   1-cycle pulse: new frame measurement valid on *_i below
//  vtotal_i          in   11  measured lines per frame/field
//  pcnt_frame_i      in   20  measured clocks per frame
//  interlace_i       in   1   measured interlace flag
//  hsync_width_i     in   8   measured hsync width (latched only, not compared)
//  irq_ack_i         in   1   CPU clears irq_o
//  state_o           out  3   current FSM state encoding
//  mode_valid_o      out  1   high only in LOCKED
//  fe_blank_o        out  1   = ~mode_valid_o; gates frontend DE
//  irq_o             out  1   sticky lock/unlock interrupt
//  lock_vtotal_o     out  11  vtotal latched at lock
//  lock_pcnt_o       out  20  pcnt_frame latched at lock
//  lock_interlace_o  out  1   interlace latched at lock
//  lock_hswidth_o    out  8   hsync_width latched at lock
//  unlock_cnt_o      out  8   number of LOCKED exits, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE, mode_valid_o 0, fe_blank_o 1, irq_o 0, all lock_* 0, unlock_cnt_o 0, candidate regs 0, timeout ctr 0.
//  States: IDLE=0, NOSYNC=1, ACQUIRE=2, VERIFY=3, LOCKED=4.
//  Transition priority per cycle: ~enable_i > ~sync_active_i > timeout > frame_tick_i.
//   IDLE:    enable_i -> NOSYNC.
//   NOSYNC:  sync_active_i -> ACQUIRE; timeout ctr held 0.
//   ACQUIRE: frame_tick -> capture candidate (vtotal, pcnt, interlace, hswidth), stable_ctr=1, -> VERIFY.
//   VERIFY:  tick & match -> stable_ctr+1; if new value == STABLE_FRAMES -> LOCKED, latch lock_* from candidate.
//            tick & mismatch -> reload candidate from inputs, stable_ctr=1, stay VERIFY.
//   LOCKED:  tick & match -> stay, candidate unchanged (no drift tracking). tick & mismatch -> ACQUIRE path: reload candidate, stable_ctr=1, -> VERIFY.
//  Any exit from LOCKED (mismatch, timeout, sync loss, disable): unlock_cnt_o += 1 (saturating), irq set.
//  Entry to LOCKED: irq set. irq_ack_i clears irq_o; simultaneous set and ack -> set wins.
//  Match = |vtotal_i - cand_vtotal| <= VTOTAL_TOL (12b signed diff) AND
//          |pcnt_frame_i - cand_pcnt| <= (cand_pcnt >> PCNT_TOL_SHIFT) (21b signed diff) AND interlace_i == cand_interlace.
//  Timeout ctr (22b): cleared on frame_tick and in IDLE/NOSYNC; increments in ACQUIRE/VERIFY/LOCKED;
//   reaching TIMEOUT_CYC-1 -> NOSYNC next cycle, ctr cleared.
//  Latency: all outputs registered; mode_valid_o/lock_* update 1 cycle after the qualifying frame_tick.
//  ~sync_active_i in any state except IDLE -> NOSYNC; ~enable_i -> IDLE; both discard candidate (stable_ctr=0).
//  frame_tick_i ignored in IDLE/NOSYNC. Reset mid-lock: immediate reset values, no irq and no unlock count.
// STRUCTURE
//  Package tvp_fe_pkg: state enum (3b), measurement widths (VTOTAL_W=11, PCNT_W=20, HSW_W=8), struct fe_meas_t.
//  Sub-module fe_meas_cmp: purely combinational tolerance compare (candidate vs input -> match); FSM, counters, latches in top.
// TESTING
//  Stable 525-line NTSC: vtotal=262, pcnt=450450, interlace=1, 3 ticks -> mode_valid_o=1 one cycle after tick 3, irq_o=1, lock_vtotal_o=262.
//  Jitter: locked at pcnt=450450, tick pcnt=452000 (delta 1550 <= 1759) -> stays LOCKED; tick vtotal=264 -> VERIFY, unlock_cnt_o=1, irq_o=1.
//  Timeout: locked, no tick for 2700000 cycles -> state_o=NOSYNC, fe_blank_o=1, unlock_cnt_o incremented.
//  Mismatch during VERIFY: ticks vtotal 262,312,312,312 -> LOCKED after 4th tick with lock_vtotal_o=312.
//  irq_ack_i asserted same cycle as lock entry -> irq_o=1; ack next cycle -> irq_o=0. sync_active_i drop same cycle as tick -> NOSYNC, tick ignored.
//  Saturation: 260 forced lock/unlock cycles -> unlock_cnt_o=255; reset asserted while LOCKED -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/tvp_fe_pkg.sv
// rtl/tvp_fe_pkg.sv - shared types and widths for the TVP7002 mode-lock controller
package tvp_fe_pkg;

  localparam int VTOTAL_W = 11;
  localparam int PCNT_W   = 20;
  localparam int HSW_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NOSYNC  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_LOCKED  = 3'd4
  } fe_state_e;

  typedef struct packed {
    logic [VTOTAL_W-1:0] vtotal;
    logic [PCNT_W-1:0]   pcnt;
    logic                interlace;
    logic [HSW_W-1:0]    hswidth;
  } fe_meas_t;

  // States in which a measurement stream is expected and the watchdog runs.
  function automatic logic is_active(fe_state_e s);
    return (s == ST_ACQUIRE) || (s == ST_VERIFY) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/fe_meas_cmp.sv
// rtl/fe_meas_cmp.sv - combinational tolerance compare of a measurement against the candidate mode
module fe_meas_cmp
  import tvp_fe_pkg::*;
#(
  parameter int VTOTAL_TOL     = 1,
  parameter int PCNT_TOL_SHIFT = 8
) (
  input  logic [VTOTAL_W-1:0] cand_vtotal_i,
  input  logic [PCNT_W-1:0]   cand_pcnt_i,
  input  logic                cand_interlace_i,
  input  logic [VTOTAL_W-1:0] meas_vtotal_i,
  input  logic [PCNT_W-1:0]   meas_pcnt_i,
  input  logic                meas_interlace_i,
  output logic                match_o
);

  localparam logic [VTOTAL_W:0] VT_TOL = VTOTAL_TOL[VTOTAL_W:0];

  logic signed [VTOTAL_W:0] vt_diff;
  logic        [VTOTAL_W:0] vt_abs;
  logic signed [PCNT_W:0]   pc_diff;
  logic        [PCNT_W:0]   pc_abs;
  logic        [PCNT_W-1:0] pc_tol;

  // One extra bit on each difference so the unsigned inputs subtract without wrap.
  always_comb begin
    vt_diff = $signed({1'b0, meas_vtotal_i}) - $signed({1'b0, cand_vtotal_i});
    vt_abs  = vt_diff[VTOTAL_W] ? $unsigned(-vt_diff) : $unsigned(vt_diff);
    pc_diff = $signed({1'b0, meas_pcnt_i}) - $signed({1'b0, cand_pcnt_i});
    pc_abs  = pc_diff[PCNT_W] ? $unsigned(-pc_diff) : $unsigned(pc_diff);
    pc_tol  = cand_pcnt_i >> PCNT_TOL_SHIFT;
    match_o = (vt_abs <= VT_TOL) && (pc_abs <= {1'b0, pc_tol}) &&
              (meas_interlace_i == cand_interlace_i);
  end

endmodule

// File: rtl/tvp7002_mode_lock_ctrl.sv
// rtl/tvp7002_mode_lock_ctrl.sv - sync acquisition, mode verification and lock sequencer
module tvp7002_mode_lock_ctrl
  import tvp_fe_pkg::*;
#(
  parameter int STABLE_FRAMES  = 3,
  parameter int VTOTAL_TOL     = 1,
  parameter int PCNT_TOL_SHIFT = 8,
  parameter int TIMEOUT_CYC    = 2700000
) (
  input  logic                CLK_MEAS_i,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                sync_active_i,
  input  logic                frame_tick_i,
  input  logic [VTOTAL_W-1:0] vtotal_i,
  input  logic [PCNT_W-1:0]   pcnt_frame_i,
  input  logic                interlace_i,
  input  logic [HSW_W-1:0]    hsync_width_i,
  input  logic                irq_ack_i,
  output logic [2:0]          state_o,
  output logic                mode_valid_o,
  output logic                fe_blank_o,
  output logic                irq_o,
  output logic [VTOTAL_W-1:0] lock_vtotal_o,
  output logic [PCNT_W-1:0]   lock_pcnt_o,
  output logic                lock_interlace_o,
  output logic [HSW_W-1:0]    lock_hswidth_o,
  output logic [7:0]          unlock_cnt_o
);

  localparam logic [21:0] TO_LAST  = 22'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);

  fe_state_e   state_q, state_d;
  fe_meas_t    cand_q, cand_d;
  fe_meas_t    lock_q, lock_d;
  fe_meas_t    meas_in;
  logic [3:0]  stable_q, stable_d;
  logic [21:0] to_q, to_d;
  logic        mode_valid_q, mode_valid_d;
  logic        irq_q, irq_d;
  logic [7:0]  unlock_q, unlock_d;
  logic        match;
  logic        timeout;
  logic        entering, leaving;

  assign meas_in.vtotal    = vtotal_i;
  assign meas_in.pcnt      = pcnt_frame_i;
  assign meas_in.interlace = interlace_i;
  assign meas_in.hswidth   = hsync_width_i;

  fe_meas_cmp #(
    .VTOTAL_TOL     (VTOTAL_TOL),
    .PCNT_TOL_SHIFT (PCNT_TOL_SHIFT)
  ) u_cmp (
    .cand_vtotal_i    (cand_q.vtotal),
    .cand_pcnt_i      (cand_q.pcnt),
    .cand_interlace_i (cand_q.interlace),
    .meas_vtotal_i    (vtotal_i),
    .meas_pcnt_i      (pcnt_frame_i),
    .meas_interlace_i (interlace_i),
    .match_o          (match)
  );

  assign timeout = (to_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    if (!enable_i) begin
      state_d  = ST_IDLE;
      stable_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_NOSYNC;
        ST_NOSYNC: if (sync_active_i) state_d = ST_ACQUIRE;
        ST_ACQUIRE, ST_VERIFY, ST_LOCKED: begin
          if (!sync_active_i || timeout) begin
            state_d  = ST_NOSYNC;
            stable_d = '0;
          end else if (frame_tick_i) begin
            // A first capture or any mismatch restarts verification from this frame.
            if ((state_q == ST_ACQUIRE) || !match) begin
              cand_d   = meas_in;
              stable_d = 4'd1;
              state_d  = ST_VERIFY;
            end else if (state_q == ST_VERIFY) begin
              stable_d = stable_q + 4'd1;
              if (stable_q + 4'd1 == STABLE_N) state_d = ST_LOCKED;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    entering     = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
    leaving      = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
    lock_d       = entering ? cand_q : lock_q;
    unlock_d     = (leaving && (unlock_q != 8'hFF)) ? unlock_q + 8'd1 : unlock_q;
    irq_d        = (entering || leaving) ? 1'b1 : (irq_ack_i ? 1'b0 : irq_q);
    mode_valid_d = (state_d == ST_LOCKED);
    // The watchdog runs only while staying inside the active states between ticks.
    if (is_active(state_q) && is_active(state_d) && !frame_tick_i) to_d = to_q + 22'd1;
    else                                                          to_d = '0;
  end

  always_ff @(posedge CLK_MEAS_i) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      lock_q       <= '0;
      stable_q     <= '0;
      to_q         <= '0;
      mode_valid_q <= 1'b0;
      irq_q        <= 1'b0;
      unlock_q     <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      lock_q       <= lock_d;
      stable_q     <= stable_d;
      to_q         <= to_d;
      mode_valid_q <= mode_valid_d;
      irq_q        <= irq_d;
      unlock_q     <= unlock_d;
    end
  end

  assign state_o          = state_q;
  assign mode_valid_o     = mode_valid_q;
  assign fe_blank_o       = ~mode_valid_q;
  assign irq_o            = irq_q;
  assign lock_vtotal_o    = lock_q.vtotal;
  assign lock_pcnt_o      = lock_q.pcnt;
  assign lock_interlace_o = lock_q.interlace;
  assign lock_hswidth_o   = lock_q.hswidth;
  assign unlock_cnt_o     = unlock_q;

endmodule

// File: tb/tb_tvp7002_mode_lock_ctrl.sv
// tb/tb_tvp7002_mode_lock_ctrl.sv - self-checking bench for the mode-lock controller
module tb_tvp7002_mode_lock_ctrl;

  localparam int T      = 40;
  localparam int STABLE = 3;
  localparam int VTOL   = 1;
  localparam int SHIFT  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, sync, tick, il, ack;
  logic [10:0] vt;
  logic [19:0] pc;
  logic [7:0]  hw;
  logic [2:0]  st;
  logic        mv, blank, irq, l_il;
  logic [10:0] l_vt;
  logic [19:0] l_pc;
  logic [7:0]  l_hw, uc;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  int m_state, m_cv, m_cp, m_ci, m_ch, m_stable, m_to, m_irq;
  int m_lv, m_lp, m_li, m_lh, m_uc;

  tvp7002_mode_lock_ctrl #(
    .STABLE_FRAMES  (STABLE),
    .VTOTAL_TOL     (VTOL),
    .PCNT_TOL_SHIFT (SHIFT),
    .TIMEOUT_CYC    (T)
  ) dut (
    .CLK_MEAS_i       (clk),
    .reset            (reset),
    .enable_i         (en),
    .sync_active_i    (sync),
    .frame_tick_i     (tick),
    .vtotal_i         (vt),
    .pcnt_frame_i     (pc),
    .interlace_i      (il),
    .hsync_width_i    (hw),
    .irq_ack_i        (ack),
    .state_o          (st),
    .mode_valid_o     (mv),
    .fe_blank_o       (blank),
    .irq_o            (irq),
    .lock_vtotal_o    (l_vt),
    .lock_pcnt_o      (l_pc),
    .lock_interlace_o (l_il),
    .lock_hswidth_o   (l_hw),
    .unlock_cnt_o     (uc)
  );

  typedef struct {
    int en, sync, tick, vt, pc, il, ack;
    int e_state, e_mv, e_irq, e_lv, e_lp, e_uc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(int e, int s, int t, int v, int p, int i, int a,
                              int es, int emv, int eirq, int elv, int elp, int euc);
    vec_t r;
    r.en = e; r.sync = s; r.tick = t; r.vt = v; r.pc = p; r.il = i; r.ack = a;
    r.e_state = es; r.e_mv = emv; r.e_irq = eirq; r.e_lv = elv; r.e_lp = elp; r.e_uc = euc;
    return r;
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: rules applied directly with integer arithmetic.
  task automatic model_step(input int e, input int s, input int t, input int v,
                            input int p, input int i, input int h, input int a);
    int  ns;
    bit  ok, was_l, now_l;
    ok = (iabs(v - m_cv) <= VTOL) && (iabs(p - m_cp) <= (m_cp / (1 << SHIFT))) && (i == m_ci);
    ns = m_state;
    if (e == 0) begin ns = 0; m_stable = 0; end
    else if (m_state == 0) ns = 1;
    else if (s == 0) begin ns = 1; m_stable = 0; end
    else if (m_state == 1) ns = 2;
    else if (m_to == T - 1) begin ns = 1; m_stable = 0; end
    else if (t != 0) begin
      if (m_state == 2 || !ok) begin
        m_cv = v; m_cp = p; m_ci = i; m_ch = h; m_stable = 1; ns = 3;
      end else if (m_state == 3) begin
        m_stable = m_stable + 1;
        if (m_stable == STABLE) ns = 4;
      end
    end
    m_to  = (m_state >= 2 && ns >= 2 && t == 0) ? m_to + 1 : 0;
    was_l = (m_state == 4);
    now_l = (ns == 4);
    if (!was_l && now_l) begin
      m_lv = m_cv; m_lp = m_cp; m_li = m_ci; m_lh = m_ch;
    end
    if (was_l && !now_l && m_uc < 255) m_uc = m_uc + 1;
    if (was_l != now_l) m_irq = 1;
    else if (a != 0)    m_irq = 0;
    m_state = ns;
  endtask

  task automatic model_reset();
    m_state = 0; m_cv = 0; m_cp = 0; m_ci = 0; m_ch = 0; m_stable = 0; m_to = 0;
    m_irq = 0; m_lv = 0; m_lp = 0; m_li = 0; m_lh = 0; m_uc = 0;
  endtask

  task automatic cyc(input int e, input int s, input int t, input int v,
                     input int p, input int i, input int h, input int a);
    en = e[0]; sync = s[0]; tick = t[0]; vt = v[10:0]; pc = p[19:0];
    il = i[0]; hw = h[7:0]; ack = a[0];
    @(posedge clk);
    if (model_on) model_step(e, s, t, v, p, i, h, a);
    #1;
  endtask

  task automatic chk_model();
    chk("rnd_state", int'(st), m_state);
    chk("rnd_mode_valid", int'(mv), (m_state == 4) ? 1 : 0);
    chk("rnd_fe_blank", int'(blank), (m_state == 4) ? 0 : 1);
    chk("rnd_irq", int'(irq), m_irq);
    chk("rnd_lock_vtotal", int'(l_vt), m_lv);
    chk("rnd_lock_pcnt", int'(l_pc), m_lp);
    chk("rnd_lock_interlace", int'(l_il), m_li);
    chk("rnd_lock_hswidth", int'(l_hw), m_lh);
    chk("rnd_unlock_cnt", int'(uc), m_uc);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    en = 0; sync = 0; tick = 0; vt = '0; pc = '0; il = 0; hw = '0; ack = 0;
    cyc(1, 1, 1, 262, 450450, 1, 32, 0);
    cyc(1, 1, 1, 262, 450450, 1, 32, 0);
    chk("reset_state", int'(st), 0);
    chk("reset_mode_valid", int'(mv), 0);
    chk("reset_fe_blank", int'(blank), 1);
    chk("reset_irq", int'(irq), 0);
    chk("reset_lock_vtotal", int'(l_vt), 0);
    chk("reset_unlock_cnt", int'(uc), 0);
    reset = 1'b0;

    tbl[0]  = mk(1,1,0,  0,     0,     1,0, 1,0,0,  0,     0,0);
    tbl[1]  = mk(1,1,0,  0,     0,     1,0, 2,0,0,  0,     0,0);
    tbl[2]  = mk(1,1,1,262,450450,     1,0, 3,0,0,  0,     0,0);
    tbl[3]  = mk(1,1,0,  0,     0,     1,0, 3,0,0,  0,     0,0);
    tbl[4]  = mk(1,1,1,262,450450,     1,0, 3,0,0,  0,     0,0);
    tbl[5]  = mk(1,1,1,262,450450,     1,0, 4,1,1,262,450450,0);
    tbl[6]  = mk(1,1,0,  0,     0,     1,1, 4,1,0,262,450450,0);
    tbl[7]  = mk(1,1,1,262,452000,     1,0, 4,1,0,262,450450,0);
    tbl[8]  = mk(1,1,1,264,450450,     1,0, 3,0,1,262,450450,1);
    tbl[9]  = mk(1,1,0,  0,     0,     1,1, 3,0,0,262,450450,1);
    tbl[10] = mk(1,1,1,263,450450,     1,0, 3,0,0,262,450450,1);
    tbl[11] = mk(1,1,1,264,450450,     1,0, 4,1,1,264,450450,1);
    tbl[12] = mk(1,1,1,262,450450,     0,0, 3,0,1,264,450450,2);
    tbl[13] = mk(1,0,1,262,450450,     1,0, 1,0,1,264,450450,2);
    tbl[14] = mk(0,1,0,  0,     0,     1,1, 0,0,0,264,450450,2);
    tbl[15] = mk(1,1,0,  0,     0,     1,0, 1,0,0,264,450450,2);
    tbl[16] = mk(1,1,0,  0,     0,     1,0, 2,0,0,264,450450,2);
    tbl[17] = mk(1,1,1,262,450450,     1,0, 3,0,0,264,450450,2);
    tbl[18] = mk(1,1,1,312,500000,     1,0, 3,0,0,264,450450,2);
    tbl[19] = mk(1,1,1,312,500000,     1,0, 3,0,0,264,450450,2);
    tbl[20] = mk(1,1,1,312,500000,     1,1, 4,1,1,312,500000,2);
    tbl[21] = mk(1,1,0,  0,     0,     1,1, 4,1,0,312,500000,2);

    for (int k = 0; k < 22; k++) begin
      cyc(tbl[k].en, tbl[k].sync, tbl[k].tick, tbl[k].vt, tbl[k].pc, tbl[k].il, 32, tbl[k].ack);
      chk($sformatf("vec%0d_state", k), int'(st), tbl[k].e_state);
      chk($sformatf("vec%0d_mode_valid", k), int'(mv), tbl[k].e_mv);
      chk($sformatf("vec%0d_fe_blank", k), int'(blank), 1 - tbl[k].e_mv);
      chk($sformatf("vec%0d_irq", k), int'(irq), tbl[k].e_irq);
      chk($sformatf("vec%0d_lock_vtotal", k), int'(l_vt), tbl[k].e_lv);
      chk($sformatf("vec%0d_lock_pcnt", k), int'(l_pc), tbl[k].e_lp);
      chk($sformatf("vec%0d_unlock_cnt", k), int'(uc), tbl[k].e_uc);
    end
    chk("lock_hswidth", int'(l_hw), 32);
    chk("lock_interlace", int'(l_il), 1);

    // Watchdog: one matching tick, then silence until sync is declared lost.
    cyc(1, 1, 1, 312, 500000, 1, 32, 0);
    n = 0;
    while (st != 3'd1 && n < 4 * T) begin
      cyc(1, 1, 0, 0, 0, 1, 32, 0);
      n++;
    end
    chk("timeout_cycles", n, T);
    chk("timeout_fe_blank", int'(blank), 1);
    chk("timeout_unlock_cnt", int'(uc), 3);
    chk("timeout_irq", int'(irq), 1);

    // Repeated lock / sync-loss cycles drive the exit counter into saturation.
    for (int i = 0; i < 260; i++) begin
      cyc(1, 1, 0, 0, 0, 1, 32, 1);
      for (int j = 0; j < 3; j++) cyc(1, 1, 1, 262, 450450, 1, 32, 0);
      if (i == 0) chk("sat_first_lock", int'(st), 4);
      cyc(1, 0, 0, 0, 0, 1, 32, 0);
      if (i == 250) chk("sat_unlock_254", int'(uc), 254);
    end
    chk("sat_unlock_255", int'(uc), 255);
    chk("sat_state_nosync", int'(st), 1);

    // Reset while locked returns straight to reset values without an event.
    cyc(1, 1, 0, 0, 0, 1, 32, 1);
    for (int j = 0; j < 3; j++) cyc(1, 1, 1, 262, 450450, 1, 77, 0);
    chk("prereset_locked", int'(st), 4);
    chk("prereset_irq", int'(irq), 1);
    reset = 1'b1;
    cyc(1, 1, 0, 0, 0, 1, 32, 0);
    reset = 1'b0;
    chk("rst_lock_state", int'(st), 0);
    chk("rst_lock_mode_valid", int'(mv), 0);
    chk("rst_lock_fe_blank", int'(blank), 1);
    chk("rst_lock_irq", int'(irq), 0);
    chk("rst_lock_vtotal", int'(l_vt), 0);
    chk("rst_lock_pcnt", int'(l_pc), 0);
    chk("rst_lock_hswidth", int'(l_hw), 0);
    chk("rst_lock_unlock_cnt", int'(uc), 0);

    // Randomised phase against the reference model.
    model_reset();
    model_on = 1;
    for (int c = 0; c < 4000; c++) begin
      int r, v, p, e, s, t;
      e = ($urandom_range(0, 99) != 0) ? 1 : 0;
      s = ($urandom_range(0, 49) != 0) ? 1 : 0;
      t = (((c / 200) % 4) == 3) ? 0 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      r = $urandom_range(0, 9);
      v = (r < 6) ? 262 : (r == 6) ? 263 : (r == 7) ? 264 : (r == 8) ? 261 : 312;
      p = ($urandom_range(0, 9) == 0) ? 500000 : 450450 + $urandom_range(0, 4000) - 2000;
      cyc(e, s, t, v, p, ($urandom_range(0, 15) != 0) ? 1 : 0,
          $urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 1 : 0);
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
